// File: rtl/req_fifo_arb_pkg.sv
// Shared types and constants for the requester-to-FIFO arbiter.
package req_fifo_arb_pkg;

    localparam int STALL_CNT_W = 16;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after prio_q.
// The priority pointer advances past the winner only when a grant is issued.
module rr_arbiter
    import req_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [NUM_REQ-1:0]          valid_i,
    input  logic                        enable_i,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic [id_w(NUM_REQ)-1:0]    grant_idx_o,
    output logic                        any_grant_o
);

    localparam int ID_W = id_w(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] prio_d, prio_q;
    logic [ID_W-1:0] cand_s;
    logic [ID_W-1:0] gidx_s;
    logic            found_s;

    // Circular search starting at the priority pointer.
    always_comb begin
        cand_s  = prio_q;
        gidx_s  = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && valid_i[cand_s]) begin
                found_s = 1'b1;
                gidx_s  = cand_s;
            end else begin
                found_s = found_s;
            end
            cand_s = (cand_s == LAST_IDX) ? '0 : cand_s + 1'b1;
        end
    end

    // Grant outputs and next priority pointer.
    always_comb begin
        any_grant_o = found_s && enable_i;
        grant_idx_o = gidx_s;
        if (any_grant_o) begin
            grant_o = NUM_REQ'(1'b1) << gidx_s;
            prio_d  = (gidx_s == LAST_IDX) ? '0 : gidx_s + 1'b1;
        end else begin
            grant_o = '0;
            prio_d  = prio_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; read data is '0 while empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_d, wptr_q;
    logic [AW:0]      rptr_d, rptr_q;
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_s;
    logic             pop_s;

    // Status decode from registered pointers only.
    always_comb begin
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty_o = (wptr_q == rptr_q);
        count_o = wptr_q - rptr_q;
        push_s  = push_i && !full_o;
        pop_s   = pop_i && !empty_o;
        rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    // Next pointers and storage write.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = push_s ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop_s  ? rptr_q + 1'b1 : rptr_q;
        if (push_s) begin
            mem_d[wptr_q[AW-1:0]] = wdata_i;
        end else begin
            mem_d = mem_q;
        end
    end

    // Pointer registers; reset discards all queued entries.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: it is masked by the empty check.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/req_fifo_arbiter.sv
// NUM_REQ requesters share one FIFO through a round-robin arbiter.
// Optional saturating stall counter: define REQ_FIFO_ARB_STALL_CNT_EN.
module req_fifo_arbiter
    import req_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic                              out_valid_o,
    output logic [DATA_WIDTH-1:0]             out_data_o,
    output logic [$clog2(NUM_REQ)-1:0]        out_id_o,
    input  logic                              out_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]       count_o,
    output logic [STALL_CNT_W-1:0]            stall_cnt_o
);

    localparam int ID_W = id_w(NUM_REQ);

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [DATA_WIDTH-1:0] req_data_s [NUM_REQ];
    logic [ID_W-1:0]       grant_idx_s;
    logic                  push_s;
    logic                  full_s;
    logic                  empty_s;
    entry_t                wr_entry_s;
    entry_t                rd_entry_s;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_data_s[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .valid_i     (req_valid_i),
        .enable_i    (~full_s),
        .grant_o     (req_ready_o),
        .grant_idx_o (grant_idx_s),
        .any_grant_o (push_s)
    );

    // Tag the winning payload with its requester index.
    always_comb begin
        wr_entry_s.id   = grant_idx_s;
        wr_entry_s.data = req_data_s[grant_idx_s];
    end

    sync_fifo #(
        .WIDTH (ID_W + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push_s),
        .wdata_i (wr_entry_s),
        .pop_i   (out_ready_i),
        .rdata_o (rd_entry_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_o)
    );

    // Head entry presentation; the FIFO already zeroes data when empty.
    always_comb begin
        out_valid_o = ~empty_s;
        out_data_o  = rd_entry_s.data;
        out_id_o    = rd_entry_s.id;
    end

`ifdef REQ_FIFO_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // Count cycles where someone is waiting on a full queue, saturating.
    always_comb begin
        if ((|req_valid_i) && full_s && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_req_fifo_arbiter.sv
// Randomized and directed bench for req_fifo_arbiter against a queue-based model.
module tb_req_fifo_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic [NR-1:0]  req_valid_i;
    logic [NR*DW-1:0] req_data_i;
    logic [NR-1:0]  req_ready_o;
    logic           out_valid_o;
    logic [DW-1:0]  out_data_o;
    logic [1:0]     out_id_o;
    logic           out_ready_i;
    logic [2:0]     count_o;
    logic [15:0]    stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [33:0] mq [$];
    int          m_prio;
    int          m_stall;

    req_fifo_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_id_o    (out_id_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [NR-1:0] v);
        if (mq.size() >= DEPTH) return -1;
        for (int i = 0; i < NR; i++) begin
            if (v[(m_prio + i) % NR]) return (m_prio + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [63:0] exp_stall();
`ifdef REQ_FIFO_ARB_STALL_CNT_EN
        return 64'(m_stall);
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_prio  = 0;
        m_stall = 0;
    endtask

    // One cycle: drive after negedge, check before posedge, update model at posedge.
    task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic rdy);
        int   g;
        logic pop;
        logic was_full;
        req_valid_i = v;
        req_data_i  = d;
        out_ready_i = rdy;
        #1;
        g = model_grant(v);
        was_full = (mq.size() >= DEPTH);
        check_eq("req_ready", 64'(req_ready_o), (g >= 0) ? (64'd1 << g) : 64'd0);
        check_eq("out_valid", 64'(out_valid_o), 64'(mq.size() > 0));
        check_eq("out_data", 64'(out_data_o), (mq.size() > 0) ? 64'(mq[0][31:0]) : 64'd0);
        check_eq("out_id", 64'(out_id_o), (mq.size() > 0) ? 64'(mq[0][33:32]) : 64'd0);
        check_eq("count", 64'(count_o), 64'(mq.size()));
        check_eq("stall_cnt", 64'(stall_cnt_o), exp_stall());
        pop = (mq.size() > 0) && rdy;
        @(posedge clk_i);
        if (pop) void'(mq.pop_front());
        if (g >= 0) begin
            mq.push_back({2'(g), d[g*DW +: DW]});
            m_prio = (g + 1) % NR;
        end
        if ((v != '0) && was_full && (m_stall < 65535)) m_stall++;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        #1;
        rstn_i = 1'b0;
        #1;
        model_reset();
        check_eq("rst_out_valid", 64'(out_valid_o), 64'd0);
        check_eq("rst_count", 64'(count_o), 64'd0);
        check_eq("rst_out_data", 64'(out_data_o), 64'd0);
        check_eq("rst_out_id", 64'(out_id_o), 64'd0);
        check_eq("rst_stall", 64'(stall_cnt_o), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    function automatic logic [NR*DW-1:0] rand_data();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    logic [NR*DW-1:0] dv;

    initial begin
        rstn_i = 1'b0;
        req_valid_i = '0;
        req_data_i = '0;
        out_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        do_reset();

        // Single push from requester 2
        dv = '0;
        dv[2*DW +: DW] = 32'hA5A5_0002;
        step(4'b0100, dv, 1'b0);
        step(4'b0000, dv, 1'b0);
        check_eq("tp1_valid", 64'(out_valid_o), 64'd1);
        check_eq("tp1_id", 64'(out_id_o), 64'd2);
        check_eq("tp1_data", 64'(out_data_o), 64'hA5A5_0002);

        // Round-robin fairness
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check_eq("rr_grant", 64'(req_ready_o & 4'b0000), 64'd0);
            step(4'b1111, rand_data(), 1'b1);
        end

        // Full blocking, then push and pop when full
        do_reset();
        for (int i = 0; i < 6; i++) step(4'b0010, rand_data(), 1'b0);
        check_eq("full_count", 64'(count_o), 64'd4);
`ifdef REQ_FIFO_ARB_STALL_CNT_EN
        check_eq("full_stall", 64'(stall_cnt_o), 64'd2);
`endif
        step(4'b1000, rand_data(), 1'b1);
        check_eq("pp_count_pop", 64'(count_o), 64'd3);
        step(4'b1000, rand_data(), 1'b0);
        check_eq("pp_count_acc", 64'(count_o), 64'd4);

        // Pointer hold while full
        do_reset();
        for (int i = 0; i < 4; i++) step(4'b0001, rand_data(), 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0101, rand_data(), 1'b0);
        step(4'b0101, rand_data(), 1'b1);
        req_valid_i = 4'b0101;
        #1;
        check_eq("hold_grant2", 64'(req_ready_o), 64'b0100);
        step(4'b0101, rand_data(), 1'b0);

        // Async reset mid-stream with three entries queued
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b1111, rand_data(), 1'b0);
        check_eq("pre_rst_count", 64'(count_o), 64'd3);
        do_reset();
        req_valid_i = 4'b1010;
        #1;
        check_eq("post_rst_grant", 64'(req_ready_o), 64'b0010);
        step(4'b1010, rand_data(), 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), rand_data(), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 100; i++) begin
            step(4'($urandom_range(0, 15)), rand_data(), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
